// File: rtl/requant_act_pipe.sv
// Per-lane requantise + clamp activation, 2-stage valid/ready pipeline with a saturating
// count of clamped lanes for quantisation-range tuning.
module requant_act_pipe #(
  parameter int IN_W  = 20,
  parameter int OUT_W = 8,
  parameter int CH    = 4,
  parameter int SH_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SH_W-1:0]     cfg_pre_shift,
  input  logic [IN_W-1:0]     cfg_offset,
  input  logic [SH_W-1:0]     cfg_post_shift,
  input  logic                cfg_round,
  input  logic [1:0]          cfg_mode,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [CH*IN_W-1:0]  s_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [CH*OUT_W-1:0] m_data,
  input  logic                sat_clr,
  output logic [CNT_W-1:0]    sat_cnt
);

  localparam int T1_W = IN_W + 1;
  localparam int T2_W = IN_W + 2;
  localparam int NC_W = $clog2(CH + 1);
  localparam logic signed [T2_W-1:0] SMAX = T2_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [T2_W-1:0] SMIN = -SMAX - T2_W'(1);
  localparam logic signed [T2_W-1:0] UMAX = T2_W'((1 << OUT_W) - 1);

  logic                     r_v1;
  logic signed [T1_W-1:0]   r_t1 [CH];
  logic [SH_W-1:0]          r_post;
  logic                     r_round;
  logic [1:0]               r_mode;
  logic                     r_m_valid;
  logic [CH*OUT_W-1:0]      r_m_data;
  logic [NC_W-1:0]          r_nclamp;
  logic [CNT_W-1:0]         r_sat_cnt;

  logic                     w_adv2;
  logic                     w_s_fire;
  logic signed [T1_W-1:0]   w_off_x;
  logic signed [T1_W-1:0]   w_lane_x [CH];
  logic signed [T1_W-1:0]   w_t1 [CH];
  logic [SH_W-1:0]          w_pm1;
  logic signed [T2_W-1:0]   w_t2x [CH];
  logic signed [T2_W-1:0]   w_sh [CH];
  logic signed [T2_W-1:0]   w_inc [CH];
  logic signed [T2_W-1:0]   w_q [CH];
  logic [OUT_W-1:0]         w_lane_o [CH];
  logic [CH-1:0]            w_clamp;
  logic [CH*OUT_W-1:0]      w_data2;
  logic [NC_W-1:0]          w_ncl;
  logic [CNT_W:0]           w_cnt_sum;

  assign w_adv2   = !r_m_valid || m_ready;
  assign s_ready  = !r_v1 || w_adv2;
  assign w_s_fire = s_valid && s_ready;
  assign m_valid  = r_m_valid;
  assign m_data   = r_m_data;
  assign sat_cnt  = r_sat_cnt;
  assign w_off_x  = {cfg_offset[IN_W-1], cfg_offset};

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      w_lane_x[i] = {s_data[i*IN_W + IN_W - 1], s_data[i*IN_W +: IN_W]};
      w_t1[i]     = (w_lane_x[i] >>> cfg_pre_shift) + w_off_x;
    end
  end

  // Half-up rounding as ((t1 >>> (p-1)) + 1) >>> 1: same result as adding 2^(p-1) first,
  // but cannot overflow for any post-shift value.
  always_comb begin
    w_pm1   = r_post - SH_W'(1);
    w_clamp = '0;
    w_data2 = '0;
    w_ncl   = '0;
    for (int i = 0; i < CH; i++) begin
      w_t2x[i]    = {r_t1[i][T1_W-1], r_t1[i]};
      w_sh[i]     = w_t2x[i] >>> w_pm1;
      w_inc[i]    = w_sh[i] + T2_W'(1);
      w_q[i]      = (r_round && (r_post != '0)) ? (w_inc[i] >>> 1) : (w_t2x[i] >>> r_post);
      w_lane_o[i] = w_q[i][OUT_W-1:0];
      // ReLU zeroing of negatives is the activation itself, not a range overflow: not counted.
      case (r_mode)
        2'd0: begin
          if (w_q[i] > SMAX) begin
            w_lane_o[i] = SMAX[OUT_W-1:0];
            w_clamp[i]  = 1'b1;
          end else if (w_q[i][T2_W-1]) begin
            w_lane_o[i] = '0;
          end
        end
        2'd1: begin
          if (w_q[i] > SMAX) begin
            w_lane_o[i] = SMAX[OUT_W-1:0];
            w_clamp[i]  = 1'b1;
          end else if (w_q[i] < SMIN) begin
            w_lane_o[i] = SMIN[OUT_W-1:0];
            w_clamp[i]  = 1'b1;
          end
        end
        2'd2: begin
          if (w_q[i] > UMAX) begin
            w_lane_o[i] = UMAX[OUT_W-1:0];
            w_clamp[i]  = 1'b1;
          end else if (w_q[i][T2_W-1]) begin
            w_lane_o[i] = '0;
          end
        end
        default: ;
      endcase
      w_data2[i*OUT_W +: OUT_W] = w_lane_o[i];
      w_ncl = w_ncl + NC_W'(w_clamp[i]);
    end
  end

  assign w_cnt_sum = {1'b0, r_sat_cnt} + (CNT_W + 1)'(r_nclamp);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1      <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_nclamp  <= '0;
    end else begin
      if (s_ready) r_v1 <= s_valid;
      if (w_adv2) r_m_valid <= r_v1;
      if (w_adv2 && r_v1) begin
        r_m_data <= w_data2;
        r_nclamp <= w_ncl;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_s_fire) begin
      for (int i = 0; i < CH; i++) r_t1[i] <= w_t1[i];
      r_post  <= cfg_post_shift;
      r_round <= cfg_round;
      r_mode  <= cfg_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || sat_clr) begin
      r_sat_cnt <= '0;
    end else if (r_m_valid && m_ready) begin
      r_sat_cnt <= w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_requant_act_pipe.sv
// Bench for requant_act_pipe: directed vector table, handshake corner sequences and random
// streams checked against an integer-arithmetic reference model with an expected-beat queue.
module tb_requant_act_pipe;
  localparam int IN_W = 20, OUT_W = 8, CH = 4, SH_W = 5, CNT_W = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [SH_W-1:0]     cfg_pre_shift, cfg_post_shift;
  logic [IN_W-1:0]     cfg_offset;
  logic                cfg_round;
  logic [1:0]          cfg_mode;
  logic                s_valid, s_ready, m_valid, m_ready, sat_clr;
  logic [CH*IN_W-1:0]  s_data;
  logic [CH*OUT_W-1:0] m_data;
  logic [CNT_W-1:0]    sat_cnt;

  requant_act_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .CH(CH), .SH_W(SH_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_pre_shift(cfg_pre_shift), .cfg_offset(cfg_offset),
    .cfg_post_shift(cfg_post_shift), .cfg_round(cfg_round), .cfg_mode(cfg_mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .sat_clr(sat_clr), .sat_cnt(sat_cnt));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct { logic [CH*OUT_W-1:0] d; int c; } exp_t;
  exp_t q[$];
  int exp_cnt = 0;
  bit stall_prev = 0;
  logic [CH*OUT_W-1:0] hold_data;

  // Reference: plain integer arithmetic on the real values, floor-division shifts.
  function automatic exp_t model(input logic [CH*IN_W-1:0] din, input logic [SH_W-1:0] pre,
                                 input logic [IN_W-1:0] off, input logic [SH_W-1:0] post,
                                 input logic rnd, input logic [1:0] mode);
    exp_t e;
    longint x, t1, t2, lo, hi, y;
    e.d = '0;
    e.c = 0;
    for (int i = 0; i < CH; i++) begin
      x  = longint'($signed(din[i*IN_W +: IN_W]));
      t1 = (x >>> pre) + longint'($signed(off));
      if (rnd && post > 0) t2 = (t1 + (longint'(1) <<< (post - 1))) >>> post;
      else t2 = t1 >>> post;
      lo = (mode == 2'd1) ? -128 : 0;
      hi = (mode == 2'd2) ? 255 : 127;
      y  = t2;
      if (mode != 2'd3) begin
        if (t2 > hi) begin y = hi; e.c++; end
        else if (t2 < lo) begin y = lo; if (mode == 2'd1) e.c++; end
      end
      e.d[i*OUT_W +: OUT_W] = y[7:0];
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      exp_cnt = 0;
      stall_prev = 0;
    end else begin
      chk("sat_cnt", 64'(sat_cnt), 64'(exp_cnt));
      if (stall_prev) begin
        chk("hold_valid", 64'(m_valid), 64'd1);
        chk("hold_data", 64'(m_data), 64'(hold_data));
      end
      if (m_valid) begin
        if (q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL stale_beat: got m_valid=1 expected no beat in flight at %0t", $time);
        end else if (m_ready) begin
          e = q.pop_front();
          chk("m_data", 64'(m_data), 64'(e.d));
          exp_cnt = (exp_cnt + e.c > 65535) ? 65535 : exp_cnt + e.c;
        end
      end
      if (sat_clr) exp_cnt = 0;
      stall_prev = m_valid && !m_ready;
      hold_data  = m_data;
      if (s_valid && s_ready)
        q.push_back(model(s_data, cfg_pre_shift, cfg_offset, cfg_post_shift, cfg_round, cfg_mode));
    end
  end

  typedef struct {
    logic [CH*IN_W-1:0] din; logic [SH_W-1:0] pre; logic [IN_W-1:0] off;
    logic [SH_W-1:0] post; logic rnd; logic [1:0] mode; logic [CH*OUT_W-1:0] dexp; int cnt;
  } vec_t;
  vec_t vt[7];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_cfg(input vec_t v);
    s_data = v.din; cfg_pre_shift = v.pre; cfg_offset = v.off;
    cfg_post_shift = v.post; cfg_round = v.rnd; cfg_mode = v.mode;
  endtask

  // clr: 0 none, 1 clear while the beat enters, 2 clear coincident with its transfer
  task automatic send_one(input vec_t v, input int clr, input string nm);
    set_cfg(v);
    m_ready = 1; s_valid = 1; sat_clr = (clr == 1);
    step();
    s_valid = 0; sat_clr = 0;
    chk({nm, "_lat1_valid"}, 64'(m_valid), 64'd0);
    step();
    chk({nm, "_lat2_valid"}, 64'(m_valid), 64'd1);
    chk({nm, "_data"}, 64'(m_data), 64'(v.dexp));
    sat_clr = (clr == 2);
    step();
    sat_clr = 0;
    chk({nm, "_drained"}, 64'(m_valid), 64'd0);
    if (clr == 1) chk({nm, "_cnt"}, 64'(sat_cnt), 64'(v.cnt));
    if (clr == 2) chk({nm, "_clr_cnt"}, 64'(sat_cnt), 64'd0);
  endtask

  function automatic int rnd_lane(input int span);
    return int'($urandom_range(0, 2 * span)) - span;
  endfunction

  task automatic new_beat(input int kind, input int idx);
    int span;
    span = (kind == 1 && $urandom_range(0, 1) == 1) ? 524287 : 50000;
    if (kind == 2) span = 4000;
    for (int i = 0; i < CH; i++) s_data[i*IN_W +: IN_W] = IN_W'(rnd_lane(span));
    case (kind)
      0: begin cfg_pre_shift = 2; cfg_offset = IN_W'(-128); cfg_post_shift = 5; cfg_round = 0; cfg_mode = 0; end
      2: begin cfg_pre_shift = (idx < 3) ? 5'd2 : 5'd0; cfg_offset = IN_W'(-128);
               cfg_post_shift = 5; cfg_round = 1; cfg_mode = 1; end
      default: begin
        cfg_pre_shift  = ($urandom_range(0, 9) == 0) ? SH_W'($urandom) : SH_W'($urandom_range(0, 6));
        cfg_post_shift = ($urandom_range(0, 9) == 0) ? SH_W'($urandom) : SH_W'($urandom_range(0, 12));
        cfg_offset     = IN_W'(rnd_lane(2000));
        cfg_round      = 1'($urandom);
        cfg_mode       = 2'($urandom);
      end
    endcase
  endtask

  // kind 0: stall m_ready cycles 2-6; 1: random valid/ready/config; 2: pre-shift change after beat 3
  task automatic run_stream(input int n, input int kind, input string nm);
    int sent = 0;
    int cyc = 0;
    int k = 0;
    bit acc;
    while (sent < n && cyc < 20 * n + 100) begin
      if (kind == 0) m_ready = !(cyc >= 2 && cyc <= 6);
      else if (kind == 1) m_ready = ($urandom_range(0, 3) != 0);
      else m_ready = 1;
      if (!s_valid && (kind != 1 || $urandom_range(0, 3) != 0)) begin
        new_beat(kind, sent);
        s_valid = 1;
      end
      @(negedge clk);
      acc = s_valid && s_ready;
      if (kind == 0 && cyc == 3) begin
        chk({nm, "_s_ready_full"}, 64'(s_ready), 64'd0);
        chk({nm, "_m_valid_full"}, 64'(m_valid), 64'd1);
      end
      step();
      if (acc) begin sent++; s_valid = 0; end
      cyc++;
    end
    chk({nm, "_beats_accepted"}, 64'(sent), 64'(n));
    s_valid = 0; m_ready = 1;
    while ((q.size() != 0 || m_valid) && k < 50) begin step(); k++; end
    chk({nm, "_drain_empty"}, 64'(q.size()), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{{20'sd0, -20'sd1000, 20'sd40000, 20'sd16384}, 5'd2, -20'sd128, 5'd5, 1'b0, 2'd0,
              {8'd0, 8'd0, 8'd127, 8'd124}, 1};
    vt[1] = '{{20'sd16384, 20'sd0, 20'sd100000, -20'sd1000}, 5'd2, -20'sd128, 5'd5, 1'b1, 2'd1,
              {8'h7C, 8'hFC, 8'h7F, 8'hF4}, 1};
    vt[2] = '{{20'sd200, -20'sd5, 20'sd256, 20'sd255}, 5'd0, 20'd0, 5'd0, 1'b0, 2'd2,
              {8'd200, 8'd0, 8'd255, 8'd255}, 1};
    vt[3] = '{{-20'sd200, 20'sd127, -20'sd1, 20'sd300}, 5'd0, 20'd0, 5'd0, 1'b0, 2'd3,
              {8'h38, 8'h7F, 8'hFF, 8'h2C}, 0};
    vt[4] = '{{20'h80000, 20'sd128, -20'sd128, -20'sd129}, 5'd0, 20'd0, 5'd0, 1'b0, 2'd1,
              {8'h80, 8'h7F, 8'h80, 8'h80}, 3};
    vt[5] = '{{-20'sd1, 20'sd5, -20'sd3, 20'sd3}, 5'd0, 20'd0, 5'd1, 1'b1, 2'd1,
              {8'h00, 8'h03, 8'hFF, 8'h02}, 0};
    vt[6] = '{{20'sd5000, -20'sd2000, 20'sd1000, -20'sd32}, 5'd4, 20'sd50, 5'd1, 1'b1, 2'd0,
              {8'd127, 8'd0, 8'd56, 8'd24}, 1};

    rst = 1; s_valid = 0; m_ready = 1; sat_clr = 0; s_data = '0;
    cfg_pre_shift = 0; cfg_offset = 0; cfg_post_shift = 0; cfg_round = 0; cfg_mode = 0;
    step(); step();
    rst = 0;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    chk("rst_sat_cnt", 64'(sat_cnt), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);

    for (int i = 0; i < 7; i++) send_one(vt[i], 1, $sformatf("vec%0d", i));

    run_stream(5, 0, "backpressure");
    run_stream(8, 2, "cfg_change");

    send_one(vt[4], 0, "pre_clr");
    send_one(vt[0], 2, "clr_coincident");

    run_stream(300, 1, "random");

    // 16385 beats of 4 clamped lanes each: 65540 > 2^16-1, counter must stick at all-ones.
    sat_clr = 1; step(); sat_clr = 0;
    for (int i = 0; i < CH; i++) s_data[i*IN_W +: IN_W] = 20'h7FFFF;
    cfg_pre_shift = 0; cfg_offset = 0; cfg_post_shift = 0; cfg_round = 0; cfg_mode = 1;
    m_ready = 1; s_valid = 1;
    repeat (16385) step();
    s_valid = 0;
    repeat (3) step();
    chk("sat_saturate", 64'(sat_cnt), 64'hFFFF);

    m_ready = 0;
    set_cfg(vt[4]); s_valid = 1;
    step(); step();
    s_valid = 0;
    chk("inflight_m_valid", 64'(m_valid), 64'd1);
    chk("inflight_s_ready", 64'(s_ready), 64'd0);
    rst = 1; step(); rst = 0;
    chk("midrst_m_valid", 64'(m_valid), 64'd0);
    chk("midrst_sat_cnt", 64'(sat_cnt), 64'd0);
    chk("midrst_s_ready", 64'(s_ready), 64'd1);
    m_ready = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("postrst_no_beat", 64'(m_valid), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
